mem_fifo_ctrl: RTL and testbench
================================

Name: mem_fifo_ctrl

Overview:
- Control and prefetch stage wrapped around a simple two-port RAM (one write port A, one read port B, one-cycle registered read).
- Converts the RAM into a valid/ready FIFO: drives port A from an upstream push stream, issues port-B reads, and catches the one-cycle-late read data in a 3-entry prefetch buffer.
- Upstream producer and downstream consumer see standard streaming handshakes and get full throughput. The RAM stays a separate instance.

Parameters:
- BIT_LENGTH, 64, data width; must match the RAM's data width.
- DEPTH, 16, RAM entries; power of two, ≥2. AW = $clog2(DEPTH).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_data  in  BIT_LENGTH  push data.
- in_valid  in  1  push request.
- in_ready  out  1  push accept.
- out_data  out  BIT_LENGTH  pop data (prefetch head).
- out_valid  out  1  head valid.
- out_ready  in  1  consumer accepts head.
- mem_addra  out  AW  RAM write address.
- mem_dina  out  BIT_LENGTH  RAM write data (= in_data).
- mem_ena  out  1  RAM port-A enable.
- mem_wea  out  1  RAM write enable.
- mem_addrb  out  AW  RAM read address.
- mem_enb  out  1  RAM read enable.
- mem_doutb  in  BIT_LENGTH  RAM read data, valid the cycle after mem_enb.
- count  out  AW+2  total occupancy (RAM + in flight + buffer).

Behaviour:
- State:
  - wptr and rptr: AW+1-bit registers.
  - mem_count = wptr - rptr.
  - rd_pend: 1-bit register, equal to mem_enb from the previous cycle.
  - buf_count: 0..3, with a 3-entry circular prefetch buffer.
- Reset (async, rst_n=0): wptr=rptr=0, rd_pend=0, buf_count=0, buffer head/tail indices = 0. Outputs: in_ready=1 after release, out_valid=0, out_data=0, count=0, mem_en*/wea=0, addresses=0. RAM contents are not cleared and are not relied on.
- Push:
  - in_ready = (mem_count < DEPTH), registered-state only, with no combinational path from out_ready.
  - push = in_valid & in_ready.
  - mem_ena = mem_wea = push; mem_addra = wptr[AW-1:0]; wptr increments on push.
- Read issue:
  - issue = (mem_count != 0) & (buf_count + rd_pend < 3).
  - mem_enb = issue; mem_addrb = rptr[AW-1:0]; rptr increments on issue.
  - A slot is reusable once issued, since the RAM returns old data when read and write hit the same edge.
- Capture: when rd_pend=1, mem_doutb is written into the buffer tail at the clock edge.
- Pop:
  - out_valid = (buf_count != 0); out_data = buffer head.
  - pop = out_valid & out_ready; head advances on pop.
  - Capture and pop in the same cycle leave buf_count unchanged.
- Latency: push accepted in cycle 0 into an empty FIFO → mem_enb in cycle 1 → rd_pend in cycle 2 → out_valid in cycle 3.
- Throughput: one push and one pop per cycle sustained when out_ready=1.
- Capacity: DEPTH+3 words. in_ready drops only when mem_count = DEPTH.
- count = mem_count + rd_pend + buf_count, computed combinationally from registers.
- Pointer wrap: the extra MSB distinguishes full from empty. Subtraction is modulo 2^(AW+1).
- Invariant: buf_count + rd_pend ≤ 3 always. A capture never hits a full buffer.
- Simultaneous push and issue on an empty RAM: not possible, because issue needs mem_count≠0 from registered state. Read-after-write to the same address is therefore always ≥1 cycle apart.
- Reset mid-operation: all in-flight data is discarded. Outputs take reset values immediately (asynchronous).

Optional Feature:
- Macro MEM_FIFO_PEAK_EN.
- Defined:
  - Adds input peak_clr (1) and output peak_count (AW+2).
  - peak_count registers the maximum count seen. It updates at each edge to max(peak_count, count).
  - peak_clr=1 loads the current count. It resets to 0.
- Undefined: neither port exists, and there is no extra logic.

Test Plan:
- Single word: push 0xA5 in cycle 0 with out_ready=1 → mem_wea at addr 0 in cycle 0, mem_enb at addr 0 in cycle 1, out_valid with out_data=0xA5 in cycle 3 only, count back to 0 in cycle 4.
- Fill with out_ready=0, DEPTH=16: push 1..19 continuously → 19 accepts, in_ready=0 after the 19th, count=19. Then pop all → data 1..19 in order, final out_valid=0.
- Streaming: in_valid=out_ready=1 for 100 cycles → after the 3-cycle fill, one pop per cycle, no bubbles, in_ready stays 1, data in order.
- Wrap: push/pop 40 words with random in_valid/out_ready (DEPTH=16) → pointers wrap twice, no loss or duplication, count never exceeds 19.
- Reset mid-operation: rst_n low for 1 cycle while count=7 → out_valid=0 and count=0 immediately. Next push 0x3C appears as the first output.
- MEM_FIFO_PEAK_EN: fill to 12, drain to 2 → peak_count=12. Pulse peak_clr → peak_count=2.

Source files
------------

// File: rtl/mem_fifo_ctrl.sv
// rtl/mem_fifo_ctrl.sv - valid/ready FIFO controller with a 3-entry prefetch buffer around a two-port RAM
//
// Purpose:
//   Turns an external simple two-port RAM (write port A, registered read
//   port B with one cycle of latency) into a streaming FIFO. Port A is
//   driven straight from the push handshake. Port-B reads are issued ahead
//   of the consumer. The read data arrives one cycle late and is caught in
//   a 3-entry circular prefetch buffer, whose head is the pop interface.
//
// Parameters:
//   BIT_LENGTH  data width (must match the RAM)
//   DEPTH       RAM entries, power of two, >= 2
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   in_data/in_valid/in_ready     push stream
//   out_data/out_valid/out_ready  pop stream (prefetch head)
//   mem_addra/mem_dina/mem_ena/mem_wea   RAM write port
//   mem_addrb/mem_enb/mem_doutb          RAM read port (data valid the cycle after mem_enb)
//   count             total occupancy: RAM + read in flight + prefetch buffer
//
// Optional build macro MEM_FIFO_PEAK_EN:
//   adds input peak_clr and output peak_count (high-water mark of count).

module mem_fifo_ctrl #(
    parameter int BIT_LENGTH = 64,
    parameter int DEPTH      = 16,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [BIT_LENGTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [BIT_LENGTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [AW-1:0]         mem_addra,
    output logic [BIT_LENGTH-1:0] mem_dina,
    output logic                  mem_ena,
    output logic                  mem_wea,
    output logic [AW-1:0]         mem_addrb,
    output logic                  mem_enb,
    input  logic [BIT_LENGTH-1:0] mem_doutb,
`ifdef MEM_FIFO_PEAK_EN
    input  logic                  peak_clr,
    output logic [AW+1:0]         peak_count,
`endif
    output logic [AW+1:0]         count
);

    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    // RAM pointers carry one extra MSB so full (difference DEPTH) and
    // empty (difference 0) are distinguishable; subtraction wraps naturally.
    logic [AW:0]           wptr;
    logic [AW:0]           rptr;
    logic [AW:0]           mem_count;

    // High for the cycle in which mem_doutb carries the word read last cycle.
    logic                  rd_pend;

    logic [1:0]            buf_count;
    logic [1:0]            buf_head;
    logic [1:0]            buf_tail;
    logic [BIT_LENGTH-1:0] buf_mem [3];

    logic                  push;
    logic                  issue;
    logic                  pop;

    function automatic logic [1:0] buf_next(input logic [1:0] idx);
        return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

    assign mem_count = wptr - rptr;

    // Depends only on registered state, so there is no path from out_ready.
    // The prefetch buffer absorbs three extra words beyond the RAM.
    assign in_ready  = (mem_count < FULL_LVL);
    assign push      = in_valid & in_ready;

    assign mem_ena   = push;
    assign mem_wea   = push;
    assign mem_addra = wptr[AW-1:0];
    assign mem_dina  = in_data;

    // A read is only issued if its result is guaranteed a buffer slot:
    // words already buffered plus the one in flight must leave room.
    // Because mem_count comes from registers, a word pushed this cycle can
    // never be read in the same cycle, so read-after-write is always at
    // least one edge apart. A slot freed by issue may be rewritten on the
    // same edge; the RAM returns the old word in that case.
    assign issue     = (mem_count != '0) &&
                       (({1'b0, buf_count} + {2'b00, rd_pend}) < 3'd3);
    assign mem_enb   = issue;
    assign mem_addrb = rptr[AW-1:0];

    assign out_valid = (buf_count != 2'd0);
    assign out_data  = buf_mem[buf_head];
    assign pop       = out_valid & out_ready;

    assign count     = {1'b0, mem_count}
                     + {{(AW+1){1'b0}}, rd_pend}
                     + {{AW{1'b0}}, buf_count};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr    <= '0;
            rptr    <= '0;
            rd_pend <= 1'b0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (issue) begin
                rptr <= rptr + 1'b1;
            end
            rd_pend <= issue;
        end
    end

    // Prefetch buffer. Storage is cleared on reset so out_data reads zero
    // while the FIFO is empty after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_count <= 2'd0;
            buf_head  <= 2'd0;
            buf_tail  <= 2'd0;
            for (int i = 0; i < 3; i++) begin
                buf_mem[i] <= '0;
            end
        end else begin
            // The issue throttle guarantees the buffer is never full here.
            if (rd_pend) begin
                buf_mem[buf_tail] <= mem_doutb;
                buf_tail          <= buf_next(buf_tail);
            end
            if (pop) begin
                buf_head <= buf_next(buf_head);
            end
            unique case ({rd_pend, pop})
                2'b10:   buf_count <= buf_count + 2'd1;
                2'b01:   buf_count <= buf_count - 2'd1;
                default: buf_count <= buf_count;
            endcase
        end
    end

`ifdef MEM_FIFO_PEAK_EN
    // High-water mark of count; peak_clr restarts tracking from the
    // current occupancy rather than from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            peak_count <= '0;
        end else if (peak_clr) begin
            peak_count <= count;
        end else if (count > peak_count) begin
            peak_count <= count;
        end
    end
`endif

endmodule

// File: tb/tb_mem_fifo_ctrl.sv
// tb/tb_mem_fifo_ctrl.sv - scoreboard bench for mem_fifo_ctrl with a behavioural two-port RAM

module tb_mem_fifo_ctrl;

    localparam int BL    = 64;
    localparam int DEPTH = 16;
    localparam int AW    = $clog2(DEPTH);

    logic          clk;
    logic          rst_n;
    logic [BL-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [BL-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] mem_addra;
    logic [BL-1:0] mem_dina;
    logic          mem_ena;
    logic          mem_wea;
    logic [AW-1:0] mem_addrb;
    logic          mem_enb;
    logic [BL-1:0] mem_doutb;
    logic [AW+1:0] count;
`ifdef MEM_FIFO_PEAK_EN
    logic          peak_clr;
    logic [AW+1:0] peak_count;
`endif

    int errors = 0;
    int checks = 0;
    int push_cnt = 0;
    int pop_cnt = 0;
    int max_count = 0;
    logic [BL-1:0] sb[$];
    logic [BL-1:0] ram [DEPTH];

    mem_fifo_ctrl #(.BIT_LENGTH(BL), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .mem_addra (mem_addra),
        .mem_dina  (mem_dina),
        .mem_ena   (mem_ena),
        .mem_wea   (mem_wea),
        .mem_addrb (mem_addrb),
        .mem_enb   (mem_enb),
        .mem_doutb (mem_doutb),
`ifdef MEM_FIFO_PEAK_EN
        .peak_clr  (peak_clr),
        .peak_count(peak_count),
`endif
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Two-port RAM, registered read, old data on same-edge read/write.
    always_ff @(posedge clk) begin
        if (mem_ena && mem_wea) ram[mem_addra] <= mem_dina;
        if (mem_enb) mem_doutb <= ram[mem_addrb];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Monitor at the falling edge, then advance to just after the next rising edge.
    task automatic cycle();
        logic [BL-1:0] e;
        @(negedge clk);
        chk("count_vs_model", 64'(count), 64'(sb.size()));
        if (int'(count) > max_count) max_count = int'(count);
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("spurious_pop", 64'(out_valid), 64'd0);
            end else begin
                e = sb.pop_front();
                chk("pop_data", out_data, e);
            end
            pop_cnt++;
        end
        if (in_valid && in_ready) begin
            sb.push_back(in_data);
            push_cnt++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 80 && sb.size() != 0; i++) cycle();
        chk("drain_sb_empty", 64'(sb.size()), 64'd0);
        chk("drain_out_valid", 64'(out_valid), 64'd0);
        chk("drain_count", 64'(count), 64'd0);
    endtask

    initial begin
        int base;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
`ifdef MEM_FIFO_PEAK_EN
        peak_clr  = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_mem_ena", 64'(mem_ena), 64'd0);
        chk("rst_mem_enb", 64'(mem_enb), 64'd0);
        chk("rst_addra", 64'(mem_addra), 64'd0);
        chk("rst_addrb", 64'(mem_addrb), 64'd0);
`ifdef MEM_FIFO_PEAK_EN
        chk("rst_peak", 64'(peak_count), 64'd0);
`endif
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Single word latency
        in_valid = 1'b1; in_data = 64'hA5; out_ready = 1'b1;
        #1;
        chk("sw_c0_wea", 64'(mem_wea), 64'd1);
        chk("sw_c0_ena", 64'(mem_ena), 64'd1);
        chk("sw_c0_addra", 64'(mem_addra), 64'd0);
        chk("sw_c0_dina", mem_dina, 64'hA5);
        chk("sw_c0_enb", 64'(mem_enb), 64'd0);
        cycle();
        in_valid = 1'b0;
        #1;
        chk("sw_c1_enb", 64'(mem_enb), 64'd1);
        chk("sw_c1_addrb", 64'(mem_addrb), 64'd0);
        chk("sw_c1_out_valid", 64'(out_valid), 64'd0);
        cycle();
        chk("sw_c2_out_valid", 64'(out_valid), 64'd0);
        chk("sw_c2_count", 64'(count), 64'd1);
        cycle();
        chk("sw_c3_out_valid", 64'(out_valid), 64'd1);
        chk("sw_c3_out_data", out_data, 64'hA5);
        cycle();
        chk("sw_c4_out_valid", 64'(out_valid), 64'd0);
        chk("sw_c4_count", 64'(count), 64'd0);

        // Fill to capacity with the consumer stalled
        out_ready = 1'b0;
        for (int i = 1; i <= DEPTH + 3; i++) begin
            in_valid = 1'b1; in_data = 64'(i);
            #1;
            chk("fill_in_ready", 64'(in_ready), 64'd1);
            cycle();
        end
        chk("full_in_ready", 64'(in_ready), 64'd0);
        chk("full_count", 64'(count), 64'(DEPTH + 3));
        in_data = 64'd99;
        cycle();
        chk("full_reject_count", 64'(count), 64'(DEPTH + 3));
        base = pop_cnt;
        drain();
        chk("fill_pops", 64'(pop_cnt - base), 64'(DEPTH + 3));

        // Streaming at full rate
        for (int i = 0; i < 100; i++) begin
            in_valid = 1'b1; in_data = 64'(100 + i); out_ready = 1'b1;
            #1;
            if (i >= 3) chk("stream_no_bubble", 64'(out_valid), 64'd1);
            chk("stream_in_ready", 64'(in_ready), 64'd1);
            cycle();
        end
        drain();

        // Random handshakes across pointer wraps
        base = push_cnt;
        max_count = 0;
        for (int i = 0; i < 1000 && ((push_cnt - base) < 40 || sb.size() != 0); i++) begin
            in_valid  = ((push_cnt - base) < 40) && ($urandom_range(0, 1) == 1);
            in_data   = 64'(1000 + push_cnt - base);
            out_ready = ($urandom_range(0, 1) == 1);
            cycle();
        end
        chk("wrap_pushes", 64'(push_cnt - base), 64'd40);
        chk("wrap_sb_empty", 64'(sb.size()), 64'd0);
        chk("wrap_max_count_ok", 64'(max_count <= DEPTH + 3), 64'd1);
        drain();

        // Asynchronous reset mid-operation
        out_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1; in_data = 64'(500 + i);
            cycle();
        end
        in_valid = 1'b0;
        chk("mid_count_before", 64'(count), 64'd7);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_count", 64'(count), 64'd0);
        chk("mid_rst_out_data", out_data, 64'd0);
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b1; in_data = 64'h3C; out_ready = 1'b1;
        cycle();
        in_valid = 1'b0;
        cycle();
        cycle();
        chk("mid_first_valid", 64'(out_valid), 64'd1);
        chk("mid_first_data", out_data, 64'h3C);
        drain();

`ifdef MEM_FIFO_PEAK_EN
        out_ready = 1'b0;
        for (int i = 0; i < 12; i++) begin
            in_valid = 1'b1; in_data = 64'(700 + i);
            cycle();
        end
        in_valid = 1'b0;
        cycle();
        base = pop_cnt;
        for (int i = 0; i < 60 && (pop_cnt - base) < 10; i++) begin
            out_ready = 1'b1;
            cycle();
        end
        out_ready = 1'b0;
        cycle();
        cycle();
        chk("peak_count_level", 64'(count), 64'd2);
        chk("peak_hold", 64'(peak_count), 64'd12);
        peak_clr = 1'b1;
        cycle();
        peak_clr = 1'b0;
        chk("peak_cleared", 64'(peak_count), 64'd2);
        drain();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
